id_ex_stage: RTL and testbench

//  ID/EX pipeline register fed by the register file's readData1/readData2 and decode fields.

---
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register. Captures the decoded instruction, its register
//   operands and immediate for the EX stage.
//
//   Register-file reads are combinational. A write lands on the rising edge,
//   so in the same cycle the read still returns the old value. The writeback
//   bypass covers that case. A load-use hazard stalls IF/ID and injects a
//   bubble. A flush from a resolved taken branch kills the ID slot.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   id_valid                       IF/ID holds a real instruction
//   id_rs1, id_rs2, id_rd          register indices from decode
//   id_imm                         sign-extended immediate
//   id_ctrl                        {memToReg,regWrite,memRead,memWrite,branch,aluSrc,aluOp[1:0]}
//   readData1, readData2           register-file read ports
//   wb_regWrite, wb_rd             writeback enable / destination
//   wb_writeData                   writeback data
//   flush                          kill the ID slot
//   stall                          combinational; hold PC and IF/ID
//   ex_valid                       EX slot holds a real instruction
//   ex_rs1, ex_rs2, ex_rd          registered indices for forwarding
//   ex_op1, ex_op2, ex_imm         registered operands and immediate
//   ex_ctrl                        registered control, zero when !ex_valid
//   stall_count                    saturating number of stall cycles

module id_ex_stage #(
  parameter int XLEN      = 64,
  parameter int CTRL_W    = 8,
  parameter int MEMREAD_B = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   readData1,
  input  logic [XLEN-1:0]   readData2,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_writeData,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       stall_count
);

  localparam logic [31:0] CountMax = 32'hFFFF_FFFF;

  logic              exValid;
  logic [4:0]        exRs1;
  logic [4:0]        exRs2;
  logic [4:0]        exRd;
  logic [XLEN-1:0]   exOp1;
  logic [XLEN-1:0]   exOp2;
  logic [XLEN-1:0]   exImm;
  logic [CTRL_W-1:0] exCtrl;
  logic [31:0]       stallCnt;

  logic [XLEN-1:0]   op1Sel;
  logic [XLEN-1:0]   op2Sel;
  logic              wbHit1;
  logic              wbHit2;
  logic              loadInEx;
  logic              rsMatch;
  logic              bubble;

  // Writeback bypass: a write to x0 is never forwarded.
  // A read of x0 returns zero whatever the register file reports.
  always_comb begin
    wbHit1 = wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    wbHit2 = wb_regWrite && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    op1Sel = readData1;
    op2Sel = readData2;
    if (id_rs1 == 5'd0) begin
      op1Sel = '0;
    end else if (wbHit1) begin
      op1Sel = wb_writeData;
    end
    if (id_rs2 == 5'd0) begin
      op2Sel = '0;
    end else if (wbHit2) begin
      op2Sel = wb_writeData;
    end
  end

  // Load-use hazard: the load in EX has no data until after MEM, so the
  // dependent instruction in ID waits one cycle. A flush overrides this,
  // because the ID instruction is being discarded anyway.
  always_comb begin
    loadInEx = exValid && exCtrl[MEMREAD_B] && (exRd != 5'd0);
    rsMatch  = (exRd == id_rs1) || (exRd == id_rs2);
    stall    = id_valid && loadInEx && rsMatch && !flush;
    bubble   = flush || stall;
  end

  // Pipeline register. Both a flush and a stall load an all-zero bubble.
  // Otherwise decode is captured. Control is zeroed for an invalid slot so
  // EX never sees stray write or memory enables.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      exValid <= 1'b0;
      exRs1   <= '0;
      exRs2   <= '0;
      exRd    <= '0;
      exOp1   <= '0;
      exOp2   <= '0;
      exImm   <= '0;
      exCtrl  <= '0;
    end else begin
      exValid <= id_valid;
      exRs1   <= id_rs1;
      exRs2   <= id_rs2;
      exRd    <= id_rd;
      exOp1   <= op1Sel;
      exOp2   <= op2Sel;
      exImm   <= id_imm;
      exCtrl  <= id_valid ? id_ctrl : '0;
    end
  end

  // Stall-cycle counter. It saturates instead of wrapping, so a long run
  // still reads as "very many stalls".
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != CountMax)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign ex_valid    = exValid;
  assign ex_rs1      = exRs1;
  assign ex_rs2      = exRs2;
  assign ex_rd       = exRd;
  assign ex_op1      = exOp1;
  assign ex_op2      = exOp2;
  assign ex_imm      = exImm;
  assign ex_ctrl     = exCtrl;
  assign stall_count = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. Directed scenarios check against
//   literal values. A randomized run checks against a reference model of the
//   EX slot, which is advanced on every clock edge from the documented rules.

module tb_id_ex_stage;

  localparam int XLEN = 64;
  localparam int CTRL_W = 8;
  localparam logic [7:0] CtrlLoad = 8'hE4;
  localparam logic [7:0] CtrlAdd  = 8'h42;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   readData1, readData2;
  logic              wb_regWrite;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_writeData;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]   ex_op1, ex_op2, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       stall_count;

  int errors = 0;
  int checks = 0;

  logic            mValid;
  logic [4:0]      mRs1, mRs2, mRd;
  logic [XLEN-1:0] mOp1, mOp2, mImm;
  logic [7:0]      mCtrl;
  logic [31:0]     mCnt;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .readData1(readData1), .readData2(readData2),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_writeData(wb_writeData),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Value EX should receive for one source register
  function automatic logic [XLEN-1:0] modelOperand(input logic [4:0] rs,
                                                   input logic [XLEN-1:0] rdData);
    if (rs == 5'd0) return '0;
    if (wb_regWrite && wb_rd != 5'd0 && wb_rd == rs) return wb_writeData;
    return rdData;
  endfunction

  // A load sitting in EX that writes a register the ID instruction reads
  function automatic logic modelStall();
    return id_valid && mValid && mCtrl[5] && mRd != 5'd0 &&
           (mRd == id_rs1 || mRd == id_rs2) && !flush;
  endfunction

  // Drive every ID-side input for one cycle
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [XLEN-1:0] imm,
                               input logic [7:0] ctrl, input logic [XLEN-1:0] rd1,
                               input logic [XLEN-1:0] rd2, input logic wbw,
                               input logic [4:0] wbrd, input logic [XLEN-1:0] wbd,
                               input logic fl);
    reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_imm = imm; id_ctrl = ctrl; readData1 = rd1; readData2 = rd2;
    wb_regWrite = wbw; wb_rd = wbrd; wb_writeData = wbd; flush = fl;
    #1;
  endtask

  // Advance one clock edge and update the reference EX slot
  task automatic tick();
    logic st;
    logic [XLEN-1:0] o1, o2;
    st = modelStall();
    o1 = modelOperand(id_rs1, readData1);
    o2 = modelOperand(id_rs2, readData2);
    @(posedge clk);
    if (reset) begin
      mValid = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mOp1 = 0; mOp2 = 0;
      mImm = 0; mCtrl = 0; mCnt = 0;
    end else begin
      if (st && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      if (flush || st) begin
        mValid = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mOp1 = 0; mOp2 = 0;
        mImm = 0; mCtrl = 0;
      end else begin
        mValid = id_valid; mRs1 = id_rs1; mRs2 = id_rs2; mRd = id_rd;
        mOp1 = o1; mOp2 = o2; mImm = id_imm; mCtrl = id_valid ? id_ctrl : 8'h0;
      end
    end
    #1;
  endtask

  // Reset held two cycles with a valid instruction present
  task automatic test_reset();
    applyStimulus(1, 1, 5'd3, 5'd4, 5'd7, 64'd16, CtrlLoad, 64'd4, 64'd5, 1, 5'd3, 64'd9, 0);
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h0) begin
      errors++; $display("[TB] FAIL reset_valid_ctrl got=%0b/%0h exp=0/0", ex_valid, ex_ctrl);
    end
    checks++;
    if (ex_op1 !== 64'd0 || ex_op2 !== 64'd0 || ex_imm !== 64'd0) begin
      errors++; $display("[TB] FAIL reset_data got=%0h/%0h/%0h exp=0", ex_op1, ex_op2, ex_imm);
    end
    checks++;
    if (ex_rs1 !== 5'd0 || ex_rs2 !== 5'd0 || ex_rd !== 5'd0 || stall_count !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_idx_cnt got=%0d/%0d/%0d/%0d exp=0", ex_rs1, ex_rs2, ex_rd, stall_count);
    end
  endtask

  // Plain capture with no hazards and no bypass
  task automatic test_pass_through();
    applyStimulus(0, 1, 5'd3, 5'd4, 5'd7, 64'd16, CtrlAdd, 64'd4, 64'd5, 0, 5'd0, 64'd0, 0);
    tick();
    checks++;
    if (ex_op1 !== 64'd4 || ex_op2 !== 64'd5 || ex_imm !== 64'd16) begin
      errors++; $display("[TB] FAIL pass_data got=%0d/%0d/%0d exp=4/5/16", ex_op1, ex_op2, ex_imm);
    end
    checks++;
    if (ex_valid !== 1'b1 || ex_ctrl !== CtrlAdd || ex_rs1 !== 5'd3 || ex_rd !== 5'd7) begin
      errors++; $display("[TB] FAIL pass_ctrl got=%0b/%0h/%0d/%0d exp=1/42/3/7", ex_valid, ex_ctrl, ex_rs1, ex_rd);
    end
  endtask

  // Writeback bypass on both ports, and x0 exclusion
  task automatic test_bypass();
    applyStimulus(0, 1, 5'd3, 5'd4, 5'd8, 64'd0, CtrlAdd, 64'd4, 64'd5, 1, 5'd3, 64'd99, 0);
    tick();
    checks++;
    if (ex_op1 !== 64'd99 || ex_op2 !== 64'd5) begin
      errors++; $display("[TB] FAIL bypass_rs1 got=%0d/%0d exp=99/5", ex_op1, ex_op2);
    end
    applyStimulus(0, 1, 5'd0, 5'd4, 5'd8, 64'd0, CtrlAdd, 64'd4, 64'd5, 1, 5'd0, 64'd77, 0);
    tick();
    checks++;
    if (ex_op1 !== 64'd0) begin
      errors++; $display("[TB] FAIL bypass_x0 got=%0d exp=0", ex_op1);
    end
    applyStimulus(0, 1, 5'd1, 5'd4, 5'd8, 64'd0, CtrlAdd, 64'd4, 64'd5, 1, 5'd4, 64'd55, 0);
    tick();
    checks++;
    if (ex_op1 !== 64'd4 || ex_op2 !== 64'd55) begin
      errors++; $display("[TB] FAIL bypass_rs2 got=%0d/%0d exp=4/55", ex_op1, ex_op2);
    end
  endtask

  // ld x5 followed by add x6,x5,x1: one stall cycle and one bubble
  task automatic test_load_use();
    applyStimulus(0, 1, 5'd2, 5'd0, 5'd5, 64'd8, CtrlLoad, 64'd100, 64'd0, 0, 5'd0, 64'd0, 0);
    tick();
    applyStimulus(0, 1, 5'd5, 5'd1, 5'd6, 64'd0, CtrlAdd, 64'd11, 64'd12, 0, 5'd0, 64'd0, 0);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL loaduse_stall got=%0b exp=1", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h0 || stall_count !== 32'd1) begin
      errors++; $display("[TB] FAIL loaduse_bubble got=%0b/%0h/%0d exp=0/0/1", ex_valid, ex_ctrl, stall_count);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL loaduse_selfclear got=%0b exp=0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_op1 !== 64'd11 || stall_count !== 32'd1) begin
      errors++; $display("[TB] FAIL loaduse_capture got=%0b/%0d/%0d/%0d exp=1/6/11/1", ex_valid, ex_rd, ex_op1, stall_count);
    end
  endtask

  // Flush wins over a load-use hazard and is not counted
  task automatic test_flush_stall();
    applyStimulus(0, 1, 5'd2, 5'd0, 5'd5, 64'd8, CtrlLoad, 64'd100, 64'd0, 0, 5'd0, 64'd0, 0);
    tick();
    applyStimulus(0, 1, 5'd1, 5'd5, 5'd6, 64'd0, CtrlAdd, 64'd11, 64'd12, 0, 5'd0, 64'd0, 1);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_stall got=%0b exp=0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h0 || stall_count !== 32'd1) begin
      errors++; $display("[TB] FAIL flush_bubble got=%0b/%0h/%0d exp=0/0/1", ex_valid, ex_ctrl, stall_count);
    end
  endtask

  // Reset arriving while a stall is raised drops the bubble and the count
  task automatic test_reset_mid_stall();
    applyStimulus(0, 1, 5'd2, 5'd0, 5'd5, 64'd8, CtrlLoad, 64'd100, 64'd0, 0, 5'd0, 64'd0, 0);
    tick();
    applyStimulus(1, 1, 5'd5, 5'd1, 5'd6, 64'd0, CtrlAdd, 64'd11, 64'd12, 0, 5'd0, 64'd0, 0);
    tick();
    reset = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stall_count !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_mid_stall got=%0b/%0b/%0d exp=0/0/0", stall, ex_valid, stall_count);
    end
    tick();
  endtask

  // Counter preloaded near its maximum stays pinned at all-ones
  task automatic test_saturation();
    force dut.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut.stallCnt;
    mCnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 5'd2, 5'd0, 5'd9, 64'd8, CtrlLoad, 64'd1, 64'd0, 0, 5'd0, 64'd0, 0);
      tick();
      applyStimulus(0, 1, 5'd9, 5'd9, 5'd10, 64'd0, CtrlAdd, 64'd1, 64'd1, 0, 5'd0, 64'd0, 0);
      tick();
      checks++;
      if (stall_count !== 32'hFFFF_FFFF) begin
        errors++; $display("[TB] FAIL saturate_%0d got=%0h exp=ffffffff", k, stall_count);
      end
      tick();
    end
  endtask

  // Randomized traffic with small register indices to provoke hazards
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), {$urandom, $urandom},
                    8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    ($urandom_range(0, 9) == 0));
      checks++;
      if (stall !== modelStall()) begin
        errors++; $display("[TB] FAIL rand_stall n=%0d got=%0b exp=%0b", n, stall, modelStall());
      end
      tick();
      checks++;
      if (ex_valid !== mValid || ex_ctrl !== mCtrl || stall_count !== mCnt) begin
        errors++; $display("[TB] FAIL rand_ctrl n=%0d got=%0b/%0h/%0d exp=%0b/%0h/%0d", n, ex_valid, ex_ctrl, stall_count, mValid, mCtrl, mCnt);
      end
      checks++;
      if (ex_rs1 !== mRs1 || ex_rs2 !== mRs2 || ex_rd !== mRd) begin
        errors++; $display("[TB] FAIL rand_idx n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, ex_rs1, ex_rs2, ex_rd, mRs1, mRs2, mRd);
      end
      checks++;
      if (ex_op1 !== mOp1 || ex_op2 !== mOp2 || ex_imm !== mImm) begin
        errors++; $display("[TB] FAIL rand_data n=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", n, ex_op1, ex_op2, ex_imm, mOp1, mOp2, mImm);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_pass_through();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_saturation();
    applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 64'd0, 8'h0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
